// File: rtl/ahb_arbiter2.sv
// ahb_arbiter2: two-master AHB arbiter (M1 = I-cache fill, M2 = data path).
//
// Grant state lives directly in the HGRANT flops (GntDef / GntM1 / GntM2).
// The grant only moves on HREADY=1 edges. It is held through SEQ/BUSY beats of
// the current owner and while the owner asserts HLOCK. RETRY/SPLIT breaks
// both holds. The bus parks on master 0 (no grant) when nobody requests.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN): a hold counter bounds
// how many HREADY edges an owner may keep the bus while the other master waits.
// It never breaks a locked sequence.
//
// Parameters:
//   PRIORITY_MODE  0 = fixed (M2 over M1), 1 = round-robin
//   MAX_HOLD       owner hold limit in HREADY edges (ARB_TIMEOUT_EN only)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   HBUSREQ_M1/M2, HLOCK_M1/M2 master requests and lock requests
//   HTRANS, HREADY, HRESP      muxed bus status of the current owner
//   HGRANT_M1/M2               registered grants (at most one set)
//   HMASTER, HMASTER_D         address-phase / data-phase owner ID
//   HMASTLOCK                  current address-phase transfer is locked

module ahb_arbiter2 #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MAX_HOLD      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       HBUSREQ_M1,
    input  logic       HBUSREQ_M2,
    input  logic       HLOCK_M1,
    input  logic       HLOCK_M2,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    input  logic [1:0] HRESP,
    output logic       HGRANT_M1,
    output logic       HGRANT_M2,
    output logic [3:0] HMASTER,
    output logic [3:0] HMASTER_D,
    output logic       HMASTLOCK
);

    // Encoding doubles as {HGRANT_M2, HGRANT_M1} and as the master ID.
    typedef enum logic [1:0] {
        GntDef = 2'b00,
        GntM1  = 2'b01,
        GntM2  = 2'b10
    } gnt_e;

    gnt_e       gnt_q, gnt_d;
    gnt_e       last_q, last_d;
    gnt_e       low_pri, arb_gnt;
    logic [3:0] hmaster_q, hmaster_d;
    logic [3:0] hmaster_dp_q, hmaster_dp_d;
    logic       hmastlock_q, hmastlock_d;
    logic       owner_lock, owner_burst, rsp_retry, hold, timeout_force;

    if (MAX_HOLD == 0) begin : g_check_max_hold
        $error("ahb_arbiter2: MAX_HOLD must be non-zero");
    end

    // HTRANS belongs to the granted master only once it also owns the address
    // phase; during a handover it still reflects the previous owner.
    assign owner_lock  = (gnt_q == GntM1 && HLOCK_M1) || (gnt_q == GntM2 && HLOCK_M2);
    assign owner_burst = (gnt_q != GntDef) && (hmaster_q == {2'b00, gnt_q}) &&
                         (HTRANS == 2'b11 || HTRANS == 2'b01);
    assign rsp_retry   = (HRESP == 2'b10) || (HRESP == 2'b11);
    // A locked transfer waiting in its data phase is covered by the HREADY=0 freeze.
    assign hold        = owner_burst || owner_lock;

    // Arbitration. For round-robin the current grant holder is the reference
    // (it is about to become owner), falling back to last_q when parked, so
    // grants alternate on consecutive edges.
    always_comb begin
        if (timeout_force) begin
            low_pri = gnt_q;
        end else if (PRIORITY_MODE == 0) begin
            low_pri = GntM1;
        end else if (gnt_q != GntDef) begin
            low_pri = gnt_q;
        end else begin
            low_pri = last_q;
        end

        if (HBUSREQ_M1 && HBUSREQ_M2) begin
            arb_gnt = (low_pri == GntM1) ? GntM2 : GntM1;
        end else if (HBUSREQ_M2) begin
            arb_gnt = GntM2;
        end else if (HBUSREQ_M1) begin
            arb_gnt = GntM1;
        end else begin
            arb_gnt = GntDef;
        end
    end

    always_comb begin
        gnt_d        = gnt_q;
        hmaster_d    = hmaster_q;
        hmaster_dp_d = hmaster_dp_q;
        hmastlock_d  = hmastlock_q;
        last_d       = last_q;
        if (HREADY) begin
            if (rsp_retry || timeout_force || !hold) begin
                gnt_d = arb_gnt;
            end
            hmaster_d    = {2'b00, gnt_q};
            hmaster_dp_d = hmaster_q;
            hmastlock_d  = owner_lock && !rsp_retry;
            if (gnt_q != GntDef) begin
                last_d = gnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= GntDef;
            hmaster_q    <= 4'd0;
            hmaster_dp_q <= 4'd0;
            hmastlock_q  <= 1'b0;
            last_q       <= GntM2;
        end else begin
            gnt_q        <= gnt_d;
            hmaster_q    <= hmaster_d;
            hmaster_dp_q <= hmaster_dp_d;
            hmastlock_q  <= hmastlock_d;
            last_q       <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            other_req;

    assign other_req = (gnt_q == GntM1 && HBUSREQ_M2) || (gnt_q == GntM2 && HBUSREQ_M1);
    // HMASTLOCK still covers the last locked transfer for one edge after HLOCK drops.
    assign timeout_force = (hold_cnt_q == CntW'(MAX_HOLD)) && !owner_lock && !hmastlock_q;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (HREADY) begin
            if (gnt_d != gnt_q) begin
                hold_cnt_d = '0;
            end else if (other_req && hold_cnt_q != CntW'(MAX_HOLD)) begin
                hold_cnt_d = hold_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout_force = 1'b0;
`endif

    assign HGRANT_M1 = gnt_q[0];
    assign HGRANT_M2 = gnt_q[1];
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_dp_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter2.sv
// Directed bench: one fixed-priority and one round-robin arbiter share stimulus;
// each vector carries hand-computed expected outputs for both.
module tb_ahb_arbiter2;

    localparam int IDLE = 0, NONSEQ = 2, SEQ = 3;
    localparam int OKAY = 0, ERR = 1, RETRY = 2;

    logic       clk;
    logic       rst;
    logic       req1, req2, lock1, lock2, hready;
    logic [1:0] htrans, hresp;
    logic       g1_0, g2_0, ml_0, g1_1, g2_1, ml_1;
    logic [3:0] hm_0, hmd_0, hm_1, hmd_1;

    int n_cmp  = 0;
    int n_fail = 0;

    ahb_arbiter2 #(.PRIORITY_MODE(0), .MAX_HOLD(4)) dut0 (
        .clk(clk), .rst(rst),
        .HBUSREQ_M1(req1), .HBUSREQ_M2(req2), .HLOCK_M1(lock1), .HLOCK_M2(lock2),
        .HTRANS(htrans), .HREADY(hready), .HRESP(hresp),
        .HGRANT_M1(g1_0), .HGRANT_M2(g2_0), .HMASTER(hm_0), .HMASTER_D(hmd_0),
        .HMASTLOCK(ml_0)
    );

    ahb_arbiter2 #(.PRIORITY_MODE(1), .MAX_HOLD(4)) dut1 (
        .clk(clk), .rst(rst),
        .HBUSREQ_M1(req1), .HBUSREQ_M2(req2), .HLOCK_M1(lock1), .HLOCK_M2(lock2),
        .HTRANS(htrans), .HREADY(hready), .HRESP(hresp),
        .HGRANT_M1(g1_1), .HGRANT_M2(g2_1), .HMASTER(hm_1), .HMASTER_D(hmd_1),
        .HMASTLOCK(ml_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req1, req2, lock1, lock2;
        logic [1:0]  trans;
        logic        ready;
        logic [1:0]  resp;
        logic [10:0] exp0, exp1;
    } vec_t;

    // {grant (1=M1, 2=M2), HMASTER, HMASTER_D, HMASTLOCK}
    function automatic logic [10:0] pk(input int g, input int m, input int d, input int l);
        logic [10:0] r;
        r = {g[1:0], m[3:0], d[3:0], l[0]};
        return r;
    endfunction

    function automatic vec_t mk(input int r1, input int r2, input int k1, input int k2,
                                input int tr, input int rdy, input int rsp,
                                input logic [10:0] e0, input logic [10:0] e1);
        vec_t v;
        v.req1  = r1[0];
        v.req2  = r2[0];
        v.lock1 = k1[0];
        v.lock2 = k2[0];
        v.trans = tr[1:0];
        v.ready = rdy[0];
        v.resp  = rsp[1:0];
        v.exp0  = e0;
        v.exp1  = e1;
        return v;
    endfunction

    task automatic cmp_one(input string name, input string mode, input logic [10:0] a,
                           input logic [10:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s %s: got grant=%0d hmaster=%0d hmaster_d=%0d lock=%b, want grant=%0d hmaster=%0d hmaster_d=%0d lock=%b",
                     name, mode, a[10:9], a[8:5], a[4:1], a[0], e[10:9], e[8:5], e[4:1], e[0]);
        end
    endtask

    task automatic check(input string name, input logic [10:0] e0, input logic [10:0] e1);
        cmp_one(name, "fixed", {g2_0, g1_0, hm_0, hmd_0, ml_0}, e0);
        cmp_one(name, "rr",    {g2_1, g1_1, hm_1, hmd_1, ml_1}, e1);
    endtask

    task automatic apply(input vec_t v, input string name);
        req1   = v.req1;
        req2   = v.req2;
        lock1  = v.lock1;
        lock2  = v.lock2;
        htrans = v.trans;
        hready = v.ready;
        hresp  = v.resp;
        @(posedge clk);
        #1;
        check(name, v.exp0, v.exp1);
    endtask

    vec_t tbl[$];

    initial begin
        // Reset and first request / alternation / park / lock+retry / ERROR.
        tbl.push_back(mk(1,0,0,0,IDLE,  1,OKAY,  pk(1,0,0,0), pk(1,0,0,0)));
        tbl.push_back(mk(1,0,0,0,IDLE,  1,OKAY,  pk(1,1,0,0), pk(1,1,0,0)));
        tbl.push_back(mk(1,0,0,0,NONSEQ,1,OKAY,  pk(1,1,1,0), pk(1,1,1,0)));
        tbl.push_back(mk(1,1,0,0,NONSEQ,1,OKAY,  pk(2,1,1,0), pk(2,1,1,0)));
        tbl.push_back(mk(1,1,0,0,NONSEQ,1,OKAY,  pk(2,2,1,0), pk(1,2,1,0)));
        tbl.push_back(mk(1,1,0,0,NONSEQ,1,OKAY,  pk(2,2,2,0), pk(2,1,2,0)));
        tbl.push_back(mk(1,1,0,0,NONSEQ,1,OKAY,  pk(2,2,2,0), pk(1,2,1,0)));
        tbl.push_back(mk(1,0,0,0,IDLE,  1,OKAY,  pk(1,2,2,0), pk(1,1,2,0)));
        tbl.push_back(mk(0,0,0,0,IDLE,  1,OKAY,  pk(0,1,2,0), pk(0,1,1,0)));
        tbl.push_back(mk(0,0,0,0,IDLE,  1,OKAY,  pk(0,0,1,0), pk(0,0,1,0)));
        tbl.push_back(mk(0,1,0,0,IDLE,  0,OKAY,  pk(0,0,1,0), pk(0,0,1,0)));
        tbl.push_back(mk(0,1,0,0,IDLE,  1,OKAY,  pk(2,0,0,0), pk(2,0,0,0)));
        tbl.push_back(mk(1,1,0,1,IDLE,  1,OKAY,  pk(2,2,0,1), pk(2,2,0,1)));
        tbl.push_back(mk(1,1,0,1,NONSEQ,1,OKAY,  pk(2,2,2,1), pk(2,2,2,1)));
        tbl.push_back(mk(1,1,0,1,NONSEQ,1,RETRY, pk(2,2,2,0), pk(1,2,2,0)));
        tbl.push_back(mk(1,0,0,0,IDLE,  1,OKAY,  pk(1,2,2,0), pk(1,1,2,0)));
        tbl.push_back(mk(1,0,0,0,IDLE,  1,OKAY,  pk(1,1,2,0), pk(1,1,1,0)));
        tbl.push_back(mk(1,1,0,0,SEQ,   1,ERR,   pk(1,1,1,0), pk(1,1,1,0)));
        tbl.push_back(mk(1,1,0,0,IDLE,  1,OKAY,  pk(2,1,1,0), pk(2,1,1,0)));
        tbl.push_back(mk(0,0,0,0,IDLE,  1,OKAY,  pk(0,2,1,0), pk(0,2,1,0)));
        tbl.push_back(mk(0,0,0,0,IDLE,  1,OKAY,  pk(0,0,2,0), pk(0,0,2,0)));

        rst    = 1'b1;
        req1   = 1'b0;
        req2   = 1'b0;
        lock1  = 1'b0;
        lock2  = 1'b0;
        htrans = 2'b00;
        hready = 1'b1;
        hresp  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", pk(0,0,0,0), pk(0,0,0,0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // M1 4-beat burst, two wait states on beat 2, M2 requesting from beat 2.
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,0,0,0), pk(1,0,0,0)), "burst_gnt");
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,1,0,0), pk(1,1,0,0)), "burst_own");
        apply(mk(1,0,0,0,NONSEQ,1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_b1");
        apply(mk(1,1,0,0,SEQ,   0,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_wait1");
        apply(mk(1,1,0,0,SEQ,   0,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_wait2");
        apply(mk(1,1,0,0,SEQ,   1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_b2");
        apply(mk(1,1,0,0,SEQ,   1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_b3");
        apply(mk(0,1,0,0,SEQ,   1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "burst_b4");
        apply(mk(0,1,0,0,IDLE,  1,OKAY, pk(2,1,1,0), pk(2,1,1,0)), "burst_handover");
        apply(mk(0,1,0,0,IDLE,  1,OKAY, pk(2,2,1,0), pk(2,2,1,0)), "burst_m2_owns");

`ifdef ARB_TIMEOUT_EN
        // Unbounded M1 burst: four counting edges, forced handover on the fifth.
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,2,2,0), pk(1,2,2,0)), "tmo_gnt");
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,1,2,0), pk(1,1,2,0)), "tmo_own");
        apply(mk(1,0,0,0,NONSEQ,1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "tmo_b1");
        for (int i = 0; i < 4; i++) begin
            apply(mk(1,1,0,0,SEQ,1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), $sformatf("tmo_hold%0d", i));
        end
        apply(mk(1,1,0,0,SEQ,   1,OKAY, pk(2,1,1,0), pk(2,1,1,0)), "tmo_force");
        // Same with HLOCK_M1: saturated counter waits for the lock to clear.
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,2,1,0), pk(1,2,1,0)), "tlk_gnt");
        apply(mk(1,0,0,0,IDLE,  1,OKAY, pk(1,1,2,0), pk(1,1,2,0)), "tlk_own");
        apply(mk(1,0,1,0,NONSEQ,1,OKAY, pk(1,1,1,1), pk(1,1,1,1)), "tlk_b1");
        for (int i = 0; i < 6; i++) begin
            apply(mk(1,1,1,0,SEQ,1,OKAY, pk(1,1,1,1), pk(1,1,1,1)), $sformatf("tlk_hold%0d", i));
        end
        apply(mk(1,1,0,0,SEQ,   1,OKAY, pk(1,1,1,0), pk(1,1,1,0)), "tlk_unlock");
        apply(mk(1,1,0,0,SEQ,   1,OKAY, pk(2,1,1,0), pk(2,1,1,0)), "tlk_force");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
